// File: rtl/fifo2shiftreg_pkg.sv
// Shared types and helpers for the FIFO-to-serial-frame bridge.
package fifo2shiftreg_pkg;

    // Width of one command word written into the FIFO.
    localparam int unsigned DIN_W = 16;

    // Serializer FSM states.
    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StGap
    } state_e;

    // Words per frame for a given frame width.
    function automatic int unsigned calc_wpf(input int unsigned width);
        return width / DIN_W;
    endfunction

    // Bits needed for a counter that must hold values up to max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO with occupancy count.
// Writes while full and reads while empty are ignored.
module sync_fifo #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wr_en,
    input  logic [DATA_W-1:0]     i_din,
    input  logic                  i_rd_en,
    output logic [DATA_W-1:0]     o_dout,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic [DEPTH_LOG2:0] r_count;
    logic                w_do_wr;
    logic                w_do_rd;

    assign o_full   = (r_count == DEPTH_CNT);
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_dout   = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
    assign w_do_wr  = i_wr_en & ~o_full;
    assign w_do_rd  = i_rd_en & ~o_empty;

    // Storage array; no reset needed since count gates every read.
    always_ff @(posedge i_clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_to_shiftreg.sv
// Buffers 16-bit command words and serializes WIDTH-bit frames on SCLK/DOUT/SYNCn.
// Optional build macro FIFO2SHIFTREG_LSB_FIRST_EN: frames go out LSB first and the
// first popped word lands in the least significant bits. Default is MSB first.
module fifo_to_shiftreg
    import fifo2shiftreg_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_wr_clk,
    input  logic [DIN_W-1:0] i_din,
    input  logic             i_wr_en,
    input  logic             i_wr_pulse,
    output logic             o_full,
    output logic             o_sclk,
    output logic             o_dout,
    output logic             o_syncn
);

    localparam int unsigned WPF   = calc_wpf(WIDTH);
    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam int unsigned DIV_W = cnt_width(2 * CLK_DIV);

    localparam logic [DEPTH_LOG2:0] WPF_CNT   = (DEPTH_LOG2 + 1)'(WPF);
    localparam logic [CNT_W-1:0]    LOAD_LAST = CNT_W'(WPF - 1);
    localparam logic [CNT_W-1:0]    BIT_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0]    HALF_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]    GAP_LAST  = DIV_W'(2 * CLK_DIV - 1);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [DIV_W-1:0]    r_div;
    logic [DIV_W-1:0]    w_div_nxt;
    logic [WIDTH-1:0]    r_shreg;
    logic [WIDTH-1:0]    w_shreg_nxt;
    logic                r_sclk;
    logic                w_sclk_nxt;
    logic                r_syncn;
    logic                w_syncn_nxt;
    logic                r_dout;
    logic                w_dout_nxt;
    logic                r_wr_pulse_d;

    logic                w_wr_strobe;
    logic                w_rd_en;
    logic [DIN_W-1:0]    w_fifo_dout;
    logic [DEPTH_LOG2:0] w_fifo_count;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_frame_ready;
    logic [WIDTH-1:0]    w_assembled;
    logic [WIDTH-1:0]    w_shifted;
    logic                w_first_bit;
    logic                w_next_bit;
    logic                w_unused;

    // The write port shares the main clock; the empty flag is implied by count.
    assign w_unused = i_wr_clk ^ w_fifo_empty;

    assign w_wr_strobe   = i_wr_en | (i_wr_pulse & ~r_wr_pulse_d);
    assign w_frame_ready = (w_fifo_count >= WPF_CNT);
    assign o_full        = w_fifo_full;
    assign o_sclk        = r_sclk;
    assign o_dout        = r_dout;
    assign o_syncn       = r_syncn;

`ifdef FIFO2SHIFTREG_LSB_FIRST_EN
    assign w_assembled = (r_shreg >> DIN_W) | (WIDTH'(w_fifo_dout) << (WIDTH - DIN_W));
    assign w_first_bit = w_assembled[0];
    assign w_shifted   = r_shreg >> 1;
    assign w_next_bit  = w_shifted[0];
`else
    assign w_assembled = (r_shreg << DIN_W) | WIDTH'(w_fifo_dout);
    assign w_first_bit = w_assembled[WIDTH-1];
    assign w_shifted   = r_shreg << 1;
    assign w_next_bit  = w_shifted[WIDTH-1];
`endif

    sync_fifo #(
        .DATA_W     (DIN_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_wr_en (w_wr_strobe),
        .i_din   (i_din),
        .i_rd_en (w_rd_en),
        .o_dout  (w_fifo_dout),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // State, counters, shift register and registered serial outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_div        <= '0;
            r_shreg      <= '0;
            r_sclk       <= 1'b1;
            r_syncn      <= 1'b1;
            r_dout       <= 1'b0;
            r_wr_pulse_d <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_div        <= w_div_nxt;
            r_shreg      <= w_shreg_nxt;
            r_sclk       <= w_sclk_nxt;
            r_syncn      <= w_syncn_nxt;
            r_dout       <= w_dout_nxt;
            r_wr_pulse_d <= i_wr_pulse;
        end
    end

    // Next-state logic for load, bit serialization and inter-frame gap.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_div_nxt   = r_div;
        w_shreg_nxt = r_shreg;
        w_sclk_nxt  = r_sclk;
        w_syncn_nxt = r_syncn;
        w_dout_nxt  = r_dout;
        w_rd_en     = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_frame_ready) begin
                    w_state_nxt = StLoad;
                    w_cnt_nxt   = '0;
                end
            end

            StLoad: begin
                w_rd_en     = 1'b1;
                w_shreg_nxt = w_assembled;
                w_cnt_nxt   = r_cnt + 1'b1;
                // The last pop also opens the frame so SYNCn falls on the same edge.
                if (r_cnt == LOAD_LAST) begin
                    w_state_nxt = StShift;
                    w_cnt_nxt   = '0;
                    w_div_nxt   = '0;
                    w_sclk_nxt  = 1'b1;
                    w_syncn_nxt = 1'b0;
                    w_dout_nxt  = w_first_bit;
                end
            end

            StShift: begin
                if (r_div == HALF_LAST) begin
                    w_div_nxt = '0;
                    if (r_sclk) begin
                        w_sclk_nxt = 1'b0;
                    end else if (r_cnt == BIT_LAST) begin
                        w_state_nxt = StGap;
                        w_sclk_nxt  = 1'b1;
                        w_syncn_nxt = 1'b1;
                        w_dout_nxt  = 1'b0;
                    end else begin
                        // DOUT only moves with the SCLK rising edge.
                        w_sclk_nxt  = 1'b1;
                        w_cnt_nxt   = r_cnt + 1'b1;
                        w_shreg_nxt = w_shifted;
                        w_dout_nxt  = w_next_bit;
                    end
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end

            StGap: begin
                if (r_div == GAP_LAST) begin
                    w_div_nxt = '0;
                    // Skip IDLE when a full frame is already waiting.
                    if (w_frame_ready) begin
                        w_state_nxt = StLoad;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end

            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_to_shiftreg.sv
// Directed self-checking bench for fifo_to_shiftreg (default MSB-first build).
module tb_fifo_to_shiftreg;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        wr_en    = 1'b0;
    logic        wr_pulse = 1'b0;
    logic [15:0] din      = 16'h0000;
    logic        full;
    logic        sclk;
    logic        dout;
    logic        syncn;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fifo_to_shiftreg #(
        .WIDTH      (32),
        .CLK_DIV    (2),
        .DEPTH_LOG2 (4)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_wr_clk   (clk),
        .i_din      (din),
        .i_wr_en    (wr_en),
        .i_wr_pulse (wr_pulse),
        .o_full     (full),
        .o_sclk     (sclk),
        .o_dout     (dout),
        .o_syncn    (syncn)
    );

    // Count negedges with SYNCn not high over a window.
    task automatic watch_idle(input int cycles, output int lows);
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (syncn !== 1'b1) lows++;
        end
    endtask

    // Wait for a frame and collect DOUT on every SCLK fall while SYNCn is low.
    task automatic capture_frame(input int max_wait, output logic [31:0] data,
                                 output int lat, output int low, output int falls,
                                 output bit ok);
        bit   started;
        logic prev;
        ok = 1'b0; started = 1'b0; data = '0; lat = 0; low = 0; falls = 0;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            lat++;
            if (syncn === 1'b0) begin
                started = 1'b1;
                break;
            end
        end
        if (started) begin
            low  = 1;
            prev = sclk;
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                if (syncn !== 1'b0) begin
                    ok = 1'b1;
                    break;
                end
                low++;
                if (prev === 1'b1 && sclk === 1'b0) begin
                    data = {data[30:0], dout};
                    falls++;
                end
                prev = sclk;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; wr_en = 1'b0; wr_pulse = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (syncn !== 1'b1) begin n_fail++; $display("FAIL reset_syncn: got %b want 1", syncn); end
        n_checks++; if (sclk !== 1'b1) begin n_fail++; $display("FAIL reset_sclk: got %b want 1", sclk); end
        n_checks++; if (dout !== 1'b0) begin n_fail++; $display("FAIL reset_dout: got %b want 0", dout); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
        n_checks++; if (dut.u_fifo.o_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", dut.u_fifo.o_count); end
        reset = 1'b0;
    endtask

    task automatic test_pulse_writes();
        logic [31:0] data; int lat, low, falls, lows; bit ok;
        @(negedge clk); din = 16'hD4B9; wr_pulse = 1'b1;
        @(negedge clk); wr_pulse = 1'b0;
        watch_idle(6, lows);
        n_checks++; if (lows !== 0) begin n_fail++; $display("FAIL partial_frame_waits: got %0d low cycles want 0", lows); end
        din = 16'hD5B9; wr_pulse = 1'b1;
        capture_frame(50, data, lat, low, falls, ok);
        wr_pulse = 1'b0;
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL pulse_frame_seen: got %b want 1", ok); end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL pulse_syncn_latency: got %0d want 4", lat); end
        n_checks++; if (data !== 32'hD4B9D5B9) begin n_fail++; $display("FAIL pulse_frame_data: got %h want d4b9d5b9", data); end
        n_checks++; if (low !== 128) begin n_fail++; $display("FAIL pulse_syncn_low: got %0d want 128", low); end
        n_checks++; if (falls !== 32) begin n_fail++; $display("FAIL pulse_sclk_falls: got %0d want 32", falls); end
        watch_idle(20, lows);
        n_checks++; if (lows !== 0) begin n_fail++; $display("FAIL pulse_no_extra_frame: got %0d want 0", lows); end
    endtask

    task automatic test_long_pulse();
        logic [31:0] data; int lat, low, falls, lows; bit ok;
        @(negedge clk); din = 16'h1234; wr_pulse = 1'b1;
        repeat (5) @(negedge clk);
        wr_pulse = 1'b0;
        watch_idle(10, lows);
        n_checks++; if (lows !== 0) begin n_fail++; $display("FAIL long_pulse_no_frame: got %0d want 0", lows); end
        n_checks++; if (dut.u_fifo.o_count !== 5'd1) begin n_fail++; $display("FAIL long_pulse_count: got %0d want 1", dut.u_fifo.o_count); end
        din = 16'h5678; wr_pulse = 1'b1;
        capture_frame(50, data, lat, low, falls, ok);
        wr_pulse = 1'b0;
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL long_pulse_frame_seen: got %b want 1", ok); end
        n_checks++; if (data !== 32'h12345678) begin n_fail++; $display("FAIL long_pulse_frame_data: got %h want 12345678", data); end
    endtask

    task automatic test_idle_gap();
        logic [31:0] data; int lat, low, falls, lows; bit ok;
        watch_idle(300, lows);
        n_checks++; if (lows !== 0) begin n_fail++; $display("FAIL idle_syncn_high: got %0d want 0", lows); end
        wr_en = 1'b1; din = 16'hD5BB;
        @(negedge clk); din = 16'hD59B;
        @(negedge clk); wr_en = 1'b0;
        capture_frame(50, data, lat, low, falls, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL idle_frame_seen: got %b want 1", ok); end
        n_checks++; if (data !== 32'hD5BBD59B) begin n_fail++; $display("FAIL idle_frame_data: got %h want d5bbd59b", data); end
        n_checks++; if (low !== 128) begin n_fail++; $display("FAIL idle_syncn_low: got %0d want 128", low); end
        watch_idle(20, lows);
        n_checks++; if (lows !== 0) begin n_fail++; $display("FAIL idle_syncn_high_after: got %0d want 0", lows); end
    endtask

    // 20 back-to-back writes: two words drain into the first frame, 16 fill the
    // FIFO, the last two are dropped. Nine frames carry words 0..17 in order.
    task automatic test_full();
        int lows;
        apply_reset();
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (i == 17) begin
                        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL full_at_15: got %b want 0", full); end
                    end
                    if (i == 18) begin
                        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_at_16: got %b want 1", full); end
                    end
                    wr_en = 1'b1;
                    din   = 16'hA000 + 16'(i);
                end
                @(negedge clk);
                wr_en = 1'b0;
                n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_after_drop: got %b want 1", full); end
                n_checks++; if (dut.u_fifo.o_count !== 5'd16) begin n_fail++; $display("FAIL full_count: got %0d want 16", dut.u_fifo.o_count); end
            end
            begin
                for (int f = 0; f < 9; f++) begin
                    logic [31:0] data, exp; int lat, low, falls; bit ok;
                    logic [15:0] w0, w1;
                    w0  = 16'hA000 + 16'(2 * f);
                    w1  = 16'hA000 + 16'(2 * f + 1);
                    exp = {w0, w1};
                    capture_frame(200, data, lat, low, falls, ok);
                    n_checks++; if (ok !== 1'b1 || data !== exp) begin
                        n_fail++; $display("FAIL full_frame_%0d: got %h ok=%b want %h", f, data, ok, exp);
                    end
                end
            end
        join
        watch_idle(300, lows);
        n_checks++; if (lows !== 0) begin n_fail++; $display("FAIL full_no_tenth_frame: got %0d want 0", lows); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL full_drained: got %b want 0", full); end
    endtask

    task automatic test_reset_mid_frame();
        int lows, falls; bit found; logic prev;
        @(negedge clk);
        wr_en = 1'b1; din = 16'hFFFF;
        repeat (4) @(negedge clk);
        wr_en = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (syncn === 1'b0) begin found = 1'b1; break; end
            @(negedge clk);
        end
        falls = 0; prev = sclk;
        for (int i = 0; i < 200 && found && falls < 10; i++) begin
            @(negedge clk);
            if (prev === 1'b1 && sclk === 1'b0) falls++;
            prev = sclk;
        end
        n_checks++; if (falls !== 10) begin n_fail++; $display("FAIL midreset_reach_bit10: got %0d falls want 10", falls); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++; if (syncn !== 1'b1) begin n_fail++; $display("FAIL midreset_syncn: got %b want 1", syncn); end
        n_checks++; if (sclk !== 1'b1) begin n_fail++; $display("FAIL midreset_sclk: got %b want 1", sclk); end
        n_checks++; if (dout !== 1'b0) begin n_fail++; $display("FAIL midreset_dout: got %b want 0", dout); end
        n_checks++; if (dut.u_fifo.o_count !== 5'd0) begin n_fail++; $display("FAIL midreset_fifo_empty: got %0d want 0", dut.u_fifo.o_count); end
        watch_idle(400, lows);
        n_checks++; if (lows !== 0) begin n_fail++; $display("FAIL midreset_no_more_frames: got %0d want 0", lows); end
    endtask

    initial begin
        test_reset();
        test_pulse_writes();
        test_long_pulse();
        test_idle_gap();
        test_full();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
